// File: rtl/tx_anc_pkg.sv
// Shared types and constants for the tx_anc DDS tone / frequency-hop generator.
package tx_anc_pkg;

  localparam int PHASE_WIDTH    = 24;
  localparam int SIN_COS_WIDTH  = 16;
  localparam int NSYMB_WIDTH    = 16;
  localparam int DATA_WIDTH     = 16;
  localparam int LUT_ADDR_WIDTH = 10;

  localparam int LUT_DEPTH   = 1 << LUT_ADDR_WIDTH;
  localparam int LUT_QUARTER = LUT_DEPTH / 4;
  localparam int LUT_PEAK    = 32767;

  // Width of the live right-shift field taken from scale_val.
  localparam int SHIFT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef logic signed [SIN_COS_WIDTH-1:0] lut_word_t;
  typedef lut_word_t lut_table_t [LUT_DEPTH];

  // Full-period sine table, rounded half away from zero. Evaluated at elaboration only.
  function automatic lut_table_t sin_table_init();
    lut_table_t tbl;
    real        two_pi;
    real        x;
    int         v;
    two_pi = 6.283185307179586;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      x = real'(LUT_PEAK) * $sin(two_pi * real'(i) / real'(LUT_DEPTH));
      v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
      tbl[i] = lut_word_t'(v);
    end
    return tbl;
  endfunction

endpackage

// File: rtl/tx_anc_sincos_lut.sv
// Registered dual-read sine/cosine ROM. One cycle latency; holds its output when en is low.
module tx_anc_sincos_lut
  import tx_anc_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clr,
  input  logic                            en,
  input  logic [LUT_ADDR_WIDTH-1:0]       addr,
  output logic signed [SIN_COS_WIDTH-1:0] sin_q,
  output logic signed [SIN_COS_WIDTH-1:0] cos_q
);

  // NOTE: the table is a constant ROM, so it has no reset; only the two read registers are cleared.
  localparam lut_table_t SIN_TABLE = sin_table_init();

  logic [LUT_ADDR_WIDTH-1:0]       cos_addr;
  logic signed [SIN_COS_WIDTH-1:0] sin_d;
  logic signed [SIN_COS_WIDTH-1:0] cos_d;

  // Cosine is the sine table read a quarter turn ahead; the index wraps naturally.
  assign cos_addr = addr + LUT_ADDR_WIDTH'(LUT_QUARTER);

  // Next read-register values: clear, load on enable, otherwise hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    sin_d = sin_q;
    cos_d = cos_q;
    if (clr) begin
      sin_d = '0;
      cos_d = '0;
    end else if (en) begin
      sin_d = SIN_TABLE[addr];
      cos_d = SIN_TABLE[cos_addr];
    end
  end

  // Read registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is always written with non-blocking assignments.
    if (!reset) begin
      sin_q <= '0;
      cos_q <= '0;
    end else begin
      sin_q <= sin_d;
      cos_q <= cos_d;
    end
  end

endmodule

// File: rtl/tx_anc.sv
// DDS tone / frequency-hop generator: phase accumulator -> sin/cos LUT -> arithmetic
// right-shift scaler, streaming one packet of nsymb x nsamp_per_symb IQ samples on AXI-S.
module tx_anc
  import tx_anc_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         srst,
  input  logic                         start,
  output logic                         busy,
  input  logic [PHASE_WIDTH-1:0]       ph_start,
  input  logic [PHASE_WIDTH-1:0]       ph_step,
  input  logic [PHASE_WIDTH-1:0]       ph_hop,
  input  logic [NSYMB_WIDTH-1:0]       nsymb,
  input  logic [NSYMB_WIDTH-1:0]       nsamp_per_symb,
  input  logic [DATA_WIDTH-1:0]        scale_val,
  output logic                         out_tvalid,
  input  logic                         out_tready,
  output logic                         out_tlast,
  output logic signed [DATA_WIDTH-1:0] itx,
  output logic signed [DATA_WIDTH-1:0] qtx,
  output logic [PHASE_WIDTH-1:0]       ph
);

  // Control state
  state_e                  state_q, state_d;
  logic                    busy_q, busy_d;

  // Latched packet parameters and running accumulators
  logic [PHASE_WIDTH-1:0]  acc_q, acc_d;
  logic [PHASE_WIDTH-1:0]  inc_q, inc_d;
  logic [PHASE_WIDTH-1:0]  hop_q, hop_d;
  logic [NSYMB_WIDTH-1:0]  nsymb_q, nsymb_d;
  logic [NSYMB_WIDTH-1:0]  nsamp_q, nsamp_d;
  logic [NSYMB_WIDTH-1:0]  symb_cnt_q, symb_cnt_d;
  logic [NSYMB_WIDTH-1:0]  samp_cnt_q, samp_cnt_d;

  // Stage 1: phase register
  logic                    v1_q, v1_d;
  logic                    last1_q, last1_d;
  logic [PHASE_WIDTH-1:0]  ph1_q, ph1_d;

  // Stage 2: side-band alongside the LUT read registers
  logic                    v2_q, v2_d;
  logic                    last2_q, last2_d;
  logic [PHASE_WIDTH-1:0]  ph2_q, ph2_d;

  // Stage 3: output register
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic signed [DATA_WIDTH-1:0] itx_q, itx_d;
  logic signed [DATA_WIDTH-1:0] qtx_q, qtx_d;
  logic [PHASE_WIDTH-1:0]  ph_q, ph_d;

  // Helpers
  logic                    en;
  logic                    issue;
  logic                    last_samp;
  logic                    last_symb;
  logic                    pkt_last;
  logic                    start_ok;
  logic                    beat_done;
  logic [SHIFT_WIDTH-1:0]  shamt;
  logic                    unused_scale_bits;
  logic signed [SIN_COS_WIDTH-1:0] sin_w;
  logic signed [SIN_COS_WIDTH-1:0] cos_w;

  // The whole pipe, including accumulators and counters, advances only when the output can move.
  assign en        = out_tready | ~tvalid_q;
  assign issue     = (state_q == RUN) & en;
  assign last_samp = (samp_cnt_q == nsamp_q - NSYMB_WIDTH'(1));
  assign last_symb = (symb_cnt_q == nsymb_q - NSYMB_WIDTH'(1));
  assign pkt_last  = last_samp & last_symb;
  assign start_ok  = start & (|nsymb) & (|nsamp_per_symb);
  assign beat_done = tvalid_q & out_tready & tlast_q;
  assign shamt     = scale_val[SHIFT_WIDTH-1:0];
  assign unused_scale_bits = ^scale_val[DATA_WIDTH-1:SHIFT_WIDTH];

  tx_anc_sincos_lut u_lut (
    .clk   (clk),
    .reset (reset),
    .clr   (srst),
    .en    (en),
    .addr  (ph1_q[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH]),
    .sin_q (sin_w),
    .cos_q (cos_w)
  );

  // Next-state: FSM, phase/increment update, counters, and pipeline shift.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    inc_d      = inc_q;
    hop_d      = hop_q;
    nsymb_d    = nsymb_q;
    nsamp_d    = nsamp_q;
    symb_cnt_d = symb_cnt_q;
    samp_cnt_d = samp_cnt_q;
    v1_d       = v1_q;
    last1_d    = last1_q;
    ph1_d      = ph1_q;
    v2_d       = v2_q;
    last2_d    = last2_q;
    ph2_d      = ph2_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    itx_d      = itx_q;
    qtx_d      = qtx_q;
    ph_d       = ph_q;

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d    = RUN;
          acc_d      = ph_start;
          inc_d      = ph_step;
          hop_d      = ph_hop;
          nsymb_d    = nsymb;
          nsamp_d    = nsamp_per_symb;
          symb_cnt_d = '0;
          samp_cnt_d = '0;
        end
      end
      RUN: begin
        if (issue) begin
          // Current sample uses acc; the next one uses acc + increment (wraps mod 2^PHASE_WIDTH).
          acc_d = acc_q + inc_q;
          if (last_samp) begin
            samp_cnt_d = '0;
            symb_cnt_d = symb_cnt_q + NSYMB_WIDTH'(1);
            inc_d      = inc_q + hop_q;
          end else begin
            samp_cnt_d = samp_cnt_q + NSYMB_WIDTH'(1);
          end
          if (pkt_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (beat_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (en) begin
      v1_d     = issue;
      last1_d  = issue & pkt_last;
      ph1_d    = acc_q;
      v2_d     = v1_q;
      last2_d  = last1_q;
      ph2_d    = ph1_q;
      tvalid_d = v2_q;
      tlast_d  = last2_q;
      ph_d     = ph2_q;
      itx_d    = cos_w >>> shamt;
      qtx_d    = sin_w >>> shamt;
    end

    // Synchronous clear abandons any packet in flight and wins over start.
    if (srst) begin
      state_d    = IDLE;
      acc_d      = '0;
      inc_d      = '0;
      hop_d      = '0;
      nsymb_d    = '0;
      nsamp_d    = '0;
      symb_cnt_d = '0;
      samp_cnt_d = '0;
      v1_d       = 1'b0;
      last1_d    = 1'b0;
      ph1_d      = '0;
      v2_d       = 1'b0;
      last2_d    = 1'b0;
      ph2_d      = '0;
      tvalid_d   = 1'b0;
      tlast_d    = 1'b0;
      itx_d      = '0;
      qtx_d      = '0;
      ph_d       = '0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      acc_q      <= '0;
      inc_q      <= '0;
      hop_q      <= '0;
      nsymb_q    <= '0;
      nsamp_q    <= '0;
      symb_cnt_q <= '0;
      samp_cnt_q <= '0;
      v1_q       <= 1'b0;
      last1_q    <= 1'b0;
      ph1_q      <= '0;
      v2_q       <= 1'b0;
      last2_q    <= 1'b0;
      ph2_q      <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      itx_q      <= '0;
      qtx_q      <= '0;
      ph_q       <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      acc_q      <= acc_d;
      inc_q      <= inc_d;
      hop_q      <= hop_d;
      nsymb_q    <= nsymb_d;
      nsamp_q    <= nsamp_d;
      symb_cnt_q <= symb_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      v1_q       <= v1_d;
      last1_q    <= last1_d;
      ph1_q      <= ph1_d;
      v2_q       <= v2_d;
      last2_q    <= last2_d;
      ph2_q      <= ph2_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      itx_q      <= itx_d;
      qtx_q      <= qtx_d;
      ph_q       <= ph_d;
    end
  end

  assign busy       = busy_q;
  assign out_tvalid = tvalid_q;
  assign out_tlast  = tlast_q;
  assign itx        = itx_q;
  assign qtx        = qtx_q;
  assign ph         = ph_q;

endmodule

// File: tb/tb_tx_anc.sv
// Self-checking bench for tx_anc: directed vector table, random packets against a
// trigonometric reference model, and hand-written reset / ignored-start sequences.
module tb_tx_anc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        srst = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic [23:0] ph_start = '0;
  logic [23:0] ph_step = '0;
  logic [23:0] ph_hop = '0;
  logic [15:0] nsymb = '0;
  logic [15:0] nsamp_per_symb = '0;
  logic [15:0] scale_val = '0;
  logic        out_tvalid;
  logic        out_tready = 1'b1;
  logic        out_tlast;
  logic signed [15:0] itx;
  logic signed [15:0] qtx;
  logic [23:0] ph;

  tx_anc dut (
    .clk            (clk),
    .reset          (reset),
    .srst           (srst),
    .start          (start),
    .busy           (busy),
    .ph_start       (ph_start),
    .ph_step        (ph_step),
    .ph_hop         (ph_hop),
    .nsymb          (nsymb),
    .nsamp_per_symb (nsamp_per_symb),
    .scale_val      (scale_val),
    .out_tvalid     (out_tvalid),
    .out_tready     (out_tready),
    .out_tlast      (out_tlast),
    .itx            (itx),
    .qtx            (qtx),
    .ph             (ph)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic [23:0]        ph;
    logic               last;
  } beat_t;

  typedef struct {
    string       name;
    logic [23:0] ps;
    logic [23:0] st;
    logic [23:0] hp;
    int          ns;
    int          nspb;
    int          sh;
    bit          rnd;
    int          nb;
    int          ei  [6];
    int          eq  [6];
    int          eph [6];
  } vec_t;

  int    n_pass = 0;
  int    n_total = 0;
  bit    rand_ready = 1'b0;
  bit    mon_en = 1'b0;
  beat_t got_q [$];
  beat_t exp_q [$];
  int    stall_cnt = 0;
  int    stall_err = 0;
  bit    stall_prev = 1'b0;
  beat_t prev_beat;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Backpressure generator: always-ready or a fair coin per cycle.
  always @(posedge clk) begin
    #1;
    out_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Output monitor: records accepted beats and watches that stalled outputs hold still.
  always @(negedge clk) begin
    beat_t cur;
    cur = '{itx, qtx, ph, out_tlast};
    if (mon_en) begin
      if (stall_prev) begin
        stall_cnt++;
        if (!out_tvalid || cur != prev_beat) stall_err++;
      end
      stall_prev = out_tvalid && !out_tready;
      prev_beat  = cur;
      if (out_tvalid && out_tready) got_q.push_back(cur);
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  function automatic int rnd_int(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic int floor_shift(input int v, input int sh);
    int d;
    d = 1 << sh;
    return (v >= 0) ? v / d : -((-v + d - 1) / d);
  endfunction

  // Expected packet: phase walks by f per sample, f grows by hop after each symbol.
  task automatic model_packet(input logic [23:0] ps, st, hp, input int ns, nspb, sh);
    longint acc, f, mask;
    int     idx, c, s;
    real    ang;
    beat_t  b;
    mask = (64'd1 << 24) - 1;
    acc  = longint'(ps);
    f    = longint'(st);
    exp_q.delete();
    for (int sy = 0; sy < ns; sy++) begin
      for (int k = 0; k < nspb; k++) begin
        idx = int'(acc >> 14);
        ang = 6.283185307179586 * real'(idx) / 1024.0;
        c = rnd_int(32767.0 * $cos(ang));
        s = rnd_int(32767.0 * $sin(ang));
        b.i    = 16'(floor_shift(c, sh));
        b.q    = 16'(floor_shift(s, sh));
        b.ph   = 24'(acc);
        b.last = (sy == ns - 1) && (k == nspb - 1);
        exp_q.push_back(b);
        acc = (acc + f) & mask;
      end
      f = (f + longint'(hp)) & mask;
    end
  endtask

  // Runs one packet, compares accepted beats with exp_q. repulse_at >= 0 pulses start mid-packet.
  task automatic run_pkt(input string tag, input logic [23:0] ps, st, hp, input int ns, nspb,
                         input logic [15:0] sc, input bit rnd, input int repulse_at);
    int base, err0, cnt0, cyc, lat, n;
    rand_ready = rnd;
    mon_en = 1'b1;
    @(posedge clk); #1;
    base = got_q.size();
    err0 = stall_err;
    cnt0 = stall_cnt;
    ph_start = ps; ph_step = st; ph_hop = hp;
    nsymb = 16'(ns); nsamp_per_symb = 16'(nspb); scale_val = sc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    lat = -1;
    while (((got_q.size() - base) < exp_q.size() || busy) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == repulse_at);
      if (start) nsymb = 16'(ns + 3);
      if (out_tvalid && lat < 0) lat = cyc;
    end
    start = 1'b0;
    check({tag, " done_in_budget"}, longint'(cyc < 3000), 1);
    if (exp_q.size() > 0) check({tag, " first_valid_latency"}, lat, 3);
    n = got_q.size() - base;
    check({tag, " beat_count"}, n, exp_q.size());
    for (int b = 0; b < exp_q.size() && b < n; b++) begin
      check($sformatf("%s b%0d itx", tag, b), got_q[base+b].i, exp_q[b].i);
      check($sformatf("%s b%0d qtx", tag, b), got_q[base+b].q, exp_q[b].q);
      check($sformatf("%s b%0d ph", tag, b), got_q[base+b].ph, exp_q[b].ph);
      check($sformatf("%s b%0d tlast", tag, b), got_q[base+b].last, exp_q[b].last);
    end
    if (stall_cnt > cnt0) check({tag, " stall_hold"}, stall_err - err0, 0);
    check({tag, " idle_tvalid"}, out_tvalid, 0);
    check({tag, " idle_busy"}, busy, 0);
    rand_ready = 1'b0;
  endtask

  vec_t vecs [4];

  initial begin
    int base;
    beat_t bt;

    vecs[0] = '{"t1_const", 24'd0, 24'd0, 24'd0, 1, 4, 0, 1'b0, 4,
                '{32767, 32767, 32767, 32767, 0, 0}, '{0, 0, 0, 0, 0, 0},
                '{0, 0, 0, 0, 0, 0}};
    vecs[1] = '{"t2_quarter", 24'd0, 24'h400000, 24'd0, 1, 4, 1, 1'b0, 4,
                '{16383, 0, -16384, 0, 0, 0}, '{0, 16383, 0, -16384, 0, 0},
                '{0, 'h400000, 'h800000, 'hC00000, 0, 0}};
    vecs[2] = '{"t3_hop", 24'd0, 24'd0, 24'h400000, 3, 2, 0, 1'b0, 6,
                '{32767, 32767, 32767, 0, -32767, 32767}, '{0, 0, 0, 32767, 0, 0},
                '{0, 0, 0, 'h400000, 'h800000, 0}};
    vecs[3] = '{"t4_backpressure", 24'd0, 24'h400000, 24'd0, 1, 4, 1, 1'b1, 4,
                '{16383, 0, -16384, 0, 0, 0}, '{0, 16383, 0, -16384, 0, 0},
                '{0, 'h400000, 'h800000, 'hC00000, 0, 0}};

    // Reset state while reset is held low.
    repeat (3) @(posedge clk);
    #2;
    check("rst busy", busy, 0);
    check("rst tvalid", out_tvalid, 0);
    check("rst tlast", out_tlast, 0);
    check("rst itx", itx, 0);
    check("rst qtx", qtx, 0);
    check("rst ph", ph, 0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vector table.
    for (int v = 0; v < 4; v++) begin
      exp_q.delete();
      for (int b = 0; b < vecs[v].nb; b++) begin
        bt.i    = 16'(vecs[v].ei[b]);
        bt.q    = 16'(vecs[v].eq[b]);
        bt.ph   = 24'(vecs[v].eph[b]);
        bt.last = (b == vecs[v].nb - 1);
        exp_q.push_back(bt);
      end
      run_pkt(vecs[v].name, vecs[v].ps, vecs[v].st, vecs[v].hp, vecs[v].ns, vecs[v].nspb,
              16'(vecs[v].sh), vecs[v].rnd, -1);
    end

    // Randomized packets against the model, with random backpressure and shift.
    for (int r = 0; r < 10; r++) begin
      logic [23:0] ps, st, hp;
      int ns, nspb, sh;
      ps = 24'($urandom); st = 24'($urandom); hp = 24'($urandom);
      ns = $urandom_range(1, 3); nspb = $urandom_range(1, 6); sh = $urandom_range(0, 15);
      model_packet(ps, st, hp, ns, nspb, sh);
      run_pkt($sformatf("rand%0d", r), ps, st, hp, ns, nspb,
              {12'($urandom), 4'(sh)}, 1'b1, -1);
    end

    // Start with zero symbols or zero samples is ignored.
    mon_en = 1'b1;
    for (int z = 0; z < 2; z++) begin
      @(posedge clk); #1;
      base = got_q.size();
      nsymb = (z == 0) ? 16'd0 : 16'd3;
      nsamp_per_symb = (z == 0) ? 16'd4 : 16'd0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("zero%0d busy", z), busy, 0);
      repeat (8) @(posedge clk);
      #1;
      check($sformatf("zero%0d beats", z), got_q.size() - base, 0);
    end

    // Start pulse during RUN must not change the packet.
    model_packet(24'h123456, 24'h010203, 24'h00F000, 2, 3, 2);
    run_pkt("restart_ignored", 24'h123456, 24'h010203, 24'h00F000, 2, 3, 16'd2, 1'b0, 2);

    // Asynchronous reset mid-packet.
    mon_en = 1'b0;
    @(posedge clk); #1;
    ph_start = 24'd0; ph_step = 24'h012345; ph_hop = 24'd0;
    nsymb = 16'd4; nsamp_per_symb = 16'd8; scale_val = 16'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    check("arst pre busy", busy, 1);
    check("arst pre tvalid", out_tvalid, 1);
    reset = 1'b0;
    #1;
    check("arst busy", busy, 0);
    check("arst tvalid", out_tvalid, 0);
    check("arst tlast", out_tlast, 0);
    check("arst itx", itx, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_packet(24'h200000, 24'h080000, 24'h010000, 2, 2, 0);
    run_pkt("after_arst", 24'h200000, 24'h080000, 24'h010000, 2, 2, 16'd0, 1'b0, -1);

    // Synchronous clear mid-packet.
    mon_en = 1'b0;
    @(posedge clk); #1;
    nsymb = 16'd4; nsamp_per_symb = 16'd8; ph_step = 24'h033333;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    check("srst busy", busy, 0);
    check("srst tvalid", out_tvalid, 0);
    check("srst tlast", out_tlast, 0);
    check("srst ph", ph, 0);
    repeat (4) @(posedge clk);
    #1;
    check("srst stays idle", out_tvalid, 0);
    model_packet(24'h000000, 24'h100000, 24'h000000, 1, 5, 3);
    run_pkt("after_srst", 24'h000000, 24'h100000, 24'h000000, 1, 5, 16'd3, 1'b1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
